k16_mem_responder: RTL



---
 rtl/k16_mem_responder_if.sv | 30 +++
 rtl/k16_mem_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/k16_mem_responder_if.sv
// k16_mem_responder_if
//   Bundles the K16 CPU memory bus and the VGA scan-out read port that the
//   responder serves.
//   CPU side   : cpu_req, cpu_address[15:0], cpu_write, cpu_wdata[15:0] in,
//                cpu_rdata[15:0], hold out (hold = CPU must keep request stable)
//   Video side : vid_req, vid_address[ADDR_BITS-1:0] in, vid_rdata[15:0] out
//   Modports   : master = requesters (CPU + video), slave = the responder.
interface k16_mem_responder_if #(
  parameter int ADDR_BITS = 12
);
  logic                 cpu_req;
  logic [15:0]          cpu_address;
  logic                 cpu_write;
  logic [15:0]          cpu_wdata;
  logic [15:0]          cpu_rdata;
  logic                 hold;
  logic                 vid_req;
  logic [ADDR_BITS-1:0] vid_address;
  logic [15:0]          vid_rdata;

  modport master (
    output cpu_req, cpu_address, cpu_write, cpu_wdata, vid_req, vid_address,
    input  cpu_rdata, hold, vid_rdata
  );

  modport slave (
    input  cpu_req, cpu_address, cpu_write, cpu_wdata, vid_req, vid_address,
    output cpu_rdata, hold, vid_rdata
  );
endinterface

// File: rtl/k16_mem_responder.sv
// k16_mem_responder
//   Memory responder for the K16 CPU. Each CPU access goes to the on-chip
//   RAM (0x0000 .. 2^ADDR_BITS-1), the 4-word I/O bank at IO_BASE
//   (LED, TIMER, SCRATCH, ID) or the unmapped region (reads 0, writes dropped).
//   The video port shares the RAM and always wins it; the CPU is stalled via
//   hold on a conflict and during the I/O wait states.
//   Ports: clk, reset (sync, active high), bus (slave modport of
//          k16_mem_responder_if), led[7:0] (LED register).
//   Optional build macro K16_ROM_PROTECT_EN: drops RAM writes below ROM_WORDS
//   and reports the drop as a sticky bit 15 of the ID register.
module k16_mem_responder #(
  parameter int          ADDR_BITS = 12,
  parameter logic [15:0] IO_BASE   = 16'hFF00,
  parameter int          IO_WAIT   = 2,
  parameter int          ROM_WORDS = 256
) (
  input  logic               clk,
  input  logic               reset,
  k16_mem_responder_if.slave bus,
  output logic [7:0]         led
);
  localparam int         RAM_WORDS = 1 << ADDR_BITS;
  // Counter preload on entering the wait state; only meaningful for IO_WAIT>0.
  localparam logic [2:0] WAIT_INIT = 3'(IO_WAIT - 1);

`ifdef K16_ROM_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  typedef enum logic {ST_IDLE, ST_IO_WAIT} state_t;

  logic [15:0] mem [RAM_WORDS];

  state_t      state, state_nxt;
  logic [2:0]  wcnt, wcnt_nxt;
  logic [15:0] timer, scratch;
  logic        rom_flag;

  logic                 sel_ram, sel_io, in_rom, rom_block;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [1:0]           io_off;
  logic                 accept, hold_c;
  logic                 ram_we, io_we;
  logic [15:0]          io_rd, rd_mux;

  // Decode. RAM is checked first so it wins if a huge ADDR_BITS overlaps IO.
  assign sel_ram  = {16'b0, bus.cpu_address} < 32'(RAM_WORDS);
  assign sel_io   = !sel_ram && (bus.cpu_address[15:2] == IO_BASE[15:2]);
  assign in_rom   = {16'b0, bus.cpu_address} < 32'(ROM_WORDS);
  assign rom_block = PROTECT && sel_ram && in_rom;
  assign ram_addr = bus.cpu_address[ADDR_BITS-1:0];
  assign io_off   = bus.cpu_address[1:0];

  always_comb begin
    io_rd = 16'h0000;
    case (io_off)
      2'd0:    io_rd = {8'h00, led};
      2'd1:    io_rd = timer;            // value before this edge's increment
      2'd2:    io_rd = scratch;
      default: io_rd = {rom_flag, 15'h4B16};
    endcase
  end

  assign rd_mux = sel_ram ? mem[ram_addr] : (sel_io ? io_rd : 16'h0000);

  // Next state / handshake
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    hold_c    = 1'b0;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          if (sel_io) begin
            if (IO_WAIT == 0) begin
              accept = 1'b1;
            end else begin
              hold_c    = 1'b1;
              state_nxt = ST_IO_WAIT;
              wcnt_nxt  = WAIT_INIT;
            end
          end else begin
            // RAM and unmapped share the path: video owns the RAM port.
            hold_c = bus.vid_req;
            accept = !bus.vid_req;
          end
        end
      end
      ST_IO_WAIT: begin
        hold_c = (wcnt != 3'd0);
        if (!bus.cpu_req) begin
          state_nxt = ST_IDLE;           // request withdrawn: abort, no write
        end else if (wcnt == 3'd0) begin
          accept    = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          wcnt_nxt = wcnt - 3'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.hold = hold_c;
  assign ram_we   = !reset && accept && bus.cpu_write && sel_ram && !rom_block;
  assign io_we    = accept && bus.cpu_write && sel_io;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wcnt          <= 3'd0;
      bus.cpu_rdata <= 16'h0000;
      bus.vid_rdata <= 16'h0000;
      led           <= 8'h00;
      timer         <= 16'h0000;
      scratch       <= 16'h0000;
      rom_flag      <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      timer <= timer + 16'd1;
      if (accept && !bus.cpu_write) bus.cpu_rdata <= rd_mux;
      if (bus.vid_req)              bus.vid_rdata <= mem[bus.vid_address];
      if (accept && bus.cpu_write && rom_block) rom_flag <= 1'b1;
      if (io_we) begin
        case (io_off)
          2'd0:    led     <= bus.cpu_wdata[7:0];
          2'd1:    timer   <= bus.cpu_wdata;   // overrides the increment
          2'd2:    scratch <= bus.cpu_wdata;
          default: ;                           // ID is read-only
        endcase
      end
    end
  end

  // RAM array is never reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= bus.cpu_wdata;
  end
endmodule
